// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, fetch status codes and the
// "no register" specifier.
package y86_pkg;

   // Instruction codes (byte 0, upper nibble)
   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   // Fetch status codes
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   // Register specifier meaning "no register"
   localparam logic [3:0] RNONE = 4'hF;

endpackage

// File: rtl/fetch_split_align.sv
// Combinational instruction splitter for the Y86-64 fetch stage: extracts
// icode/ifun/rA/rB, aligns the 8-byte constant, computes the sequential
// next PC and checks that the icode/ifun pair is a legal encoding.
module fetch_split_align
   import y86_pkg::*;
(
   input  logic [63:0] i_pc,
   input  logic [79:0] i_bytes,
   output logic [3:0]  o_icode,
   output logic [3:0]  o_ifun,
   output logic [3:0]  o_rA,
   output logic [3:0]  o_rB,
   output logic [63:0] o_valC,
   output logic [63:0] o_valP,
   output logic        o_valid
);

   logic w_need_regids;
   logic w_need_valC;

   assign o_icode = i_bytes[7:4];
   assign o_ifun  = i_bytes[3:0];

   // Decide which optional fields follow byte 0
   always_comb begin
      w_need_regids = 1'b0;
      w_need_valC   = 1'b0;
      case (o_icode)
         IRRMOVQ, IOPQ, IPUSHQ, IPOPQ: w_need_regids = 1'b1;
         IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
            w_need_regids = 1'b1;
            w_need_valC   = 1'b1;
         end
         IJXX, ICALL: w_need_valC = 1'b1;
         default: ;
      endcase
   end

   // Register specifiers and the little-endian constant word
   always_comb begin
      o_rA   = RNONE;
      o_rB   = RNONE;
      o_valC = '0;
      if (w_need_regids) begin
         o_rA = i_bytes[15:12];
         o_rB = i_bytes[11:8];
      end
      if (w_need_valC) begin
         if (w_need_regids)
            o_valC = i_bytes[79:16];
         else
            o_valC = i_bytes[71:8];
      end
   end

   // Sequential next PC, wraps modulo 2^64
   always_comb begin
      o_valP = i_pc + 64'd1 + {63'd0, w_need_regids} + (w_need_valC ? 64'd8 : 64'd0);
   end

   // Encoding legality of the icode/ifun pair
   always_comb begin
      case (o_icode)
         IRRMOVQ, IJXX: o_valid = (o_ifun <= 4'd6);
         IOPQ:          o_valid = (o_ifun <= 4'd3);
         IHALT, INOP, IIRMOVQ, IRMMOVQ, IMRMOVQ,
         ICALL, IRET, IPUSHQ, IPOPQ:
                        o_valid = (o_ifun == 4'd0);
         default:       o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: PC selection, status generation, the F pipeline
// register, the post-fault stop latch and optional performance counters.
// Optional feature macro: FETCH_PERF_CNT_EN (adds perf_fetched/perf_redirects).
module fetch_stage
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic        F_stall,
   input  logic [3:0]  M_icode,
   input  logic        M_Cnd,
   input  logic [63:0] M_valA,
   input  logic [3:0]  W_icode,
   input  logic [63:0] W_valM,
   output logic [63:0] imem_addr,
   input  logic [79:0] imem_data,
   input  logic        imem_error,
   output logic [2:0]  f_stat,
   output logic [3:0]  f_icode,
   output logic [3:0]  f_ifun,
   output logic [3:0]  f_rA,
   output logic [3:0]  f_rB,
   output logic [63:0] f_valC,
   output logic [63:0] f_valP,
   output logic [63:0] f_pc,
   output logic [63:0] f_predPC,
   output logic        f_halted
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [63:0] perf_fetched,
   output logic [63:0] perf_redirects
`endif
);

   logic [63:0] r_predPC;
   logic        r_halted;
   logic        w_mispred;
   logic        w_ret;
   logic        w_redirect;
   logic [3:0]  w_icode;
   logic [3:0]  w_ifun;
   logic        w_valid;

   assign w_mispred  = (M_icode == IJXX) && !M_Cnd;
   assign w_ret      = (W_icode == IRET);
   assign w_redirect = w_mispred || w_ret;

   // Fetch PC select: M mispredict beats W ret beats prediction
   always_comb begin
      if (w_mispred)
         f_pc = M_valA;
      else if (w_ret)
         f_pc = W_valM;
      else
         f_pc = r_predPC;
   end

   assign imem_addr = f_pc;

   fetch_split_align u_split (
      .i_pc    (f_pc),
      .i_bytes (imem_data),
      .o_icode (w_icode),
      .o_ifun  (w_ifun),
      .o_rA    (f_rA),
      .o_rB    (f_rB),
      .o_valC  (f_valC),
      .o_valP  (f_valP),
      .o_valid (w_valid)
   );

   // Status priority: memory error, illegal encoding, halt, ok
   always_comb begin
      f_stat  = SAOK;
      f_icode = w_icode;
      f_ifun  = w_ifun;
      if (imem_error) begin
         f_stat  = SADR;
         f_icode = INOP;
         f_ifun  = 4'h0;
      end else if (!w_valid) begin
         f_stat  = SINS;
         f_icode = INOP;
      end else if (w_icode == IHALT) begin
         f_stat  = SHLT;
      end
   end

   assign f_predPC = ((f_icode == IJXX) || (f_icode == ICALL)) ? f_valC : f_valP;
   assign f_halted = r_halted;

   // F register and stop latch; a redirect restarts fetch even when stopped
   always_ff @(posedge clk) begin
      if (reset) begin
         r_predPC <= RESET_PC;
         r_halted <= 1'b0;
      end else if (!F_stall) begin
         if (w_redirect) begin
            r_predPC <= f_predPC;
            r_halted <= 1'b0;
         end else if (!r_halted) begin
            r_predPC <= f_predPC;
            if (f_stat != SAOK)
               r_halted <= 1'b1;
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [63:0] r_perf_fetched;
   logic [63:0] r_perf_redirects;

   // Count good fetches and redirects on non-stalled edges
   always_ff @(posedge clk) begin
      if (reset) begin
         r_perf_fetched   <= '0;
         r_perf_redirects <= '0;
      end else if (!F_stall) begin
         if (!r_halted && (f_stat == SAOK))
            r_perf_fetched <= r_perf_fetched + 64'd1;
         if (w_redirect)
            r_perf_redirects <= r_perf_redirects + 64'd1;
      end
   end

   assign perf_fetched   = r_perf_fetched;
   assign perf_redirects = r_perf_redirects;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a vector table for the combinational
// decode path plus hand sequences for the register, stall and halt latch.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        F_stall;
   logic [3:0]  M_icode;
   logic        M_Cnd;
   logic [63:0] M_valA;
   logic [3:0]  W_icode;
   logic [63:0] W_valM;
   logic [63:0] imem_addr;
   logic [79:0] imem_data;
   logic        imem_error;
   logic [2:0]  f_stat;
   logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
   logic [63:0] f_valC, f_valP, f_pc, f_predPC;
   logic        f_halted;
`ifdef FETCH_PERF_CNT_EN
   logic [63:0] perf_fetched, perf_redirects;
`endif

   int checks = 0;
   int errors = 0;

   localparam logic [79:0] NOP_DATA = 80'h0000_0000_0000_0000_0010;

   fetch_stage #(.RESET_PC(64'h0)) dut (
      .clk        (clk),
      .reset      (reset),
      .F_stall    (F_stall),
      .M_icode    (M_icode),
      .M_Cnd      (M_Cnd),
      .M_valA     (M_valA),
      .W_icode    (W_icode),
      .W_valM     (W_valM),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_error (imem_error),
      .f_stat     (f_stat),
      .f_icode    (f_icode),
      .f_ifun     (f_ifun),
      .f_rA       (f_rA),
      .f_rB       (f_rB),
      .f_valC     (f_valC),
      .f_valP     (f_valP),
      .f_pc       (f_pc),
      .f_predPC   (f_predPC),
      .f_halted   (f_halted)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] pc;
      logic [79:0] data;
      logic        err;
      logic [2:0]  stat;
      logic [3:0]  icode;
      logic [3:0]  ifun;
      logic [3:0]  rA;
      logic [3:0]  rB;
      logic [63:0] valC;
      logic [63:0] valP;
      logic [63:0] pred;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mkv(input logic [63:0] pc, input logic [79:0] data,
                                input logic err, input logic [2:0] stat,
                                input logic [3:0] icode, input logic [3:0] ifun,
                                input logic [3:0] rA, input logic [3:0] rB,
                                input logic [63:0] valC, input logic [63:0] valP,
                                input logic [63:0] pred);
      vec_t v;
      v.pc = pc; v.data = data; v.err = err; v.stat = stat;
      v.icode = icode; v.ifun = ifun; v.rA = rA; v.rB = rB;
      v.valC = valC; v.valP = valP; v.pred = pred;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          pc                     data                          err stat  ic    if    rA    rB    valC                   valP                   pred
      vecs[0]  = mkv(64'h0,   80'h0000_0000_0000_000A_F230, 0, 3'd1, 4'h3, 4'h0, 4'hF, 4'h2, 64'hA,  64'hA,  64'hA);
      vecs[1]  = mkv(64'h20,  80'h0000_0000_0000_0001_0070, 0, 3'd1, 4'h7, 4'h0, 4'hF, 4'hF, 64'h100, 64'h29, 64'h100);
      vecs[2]  = mkv(64'h40,  80'hFFFF_FFFF_FFFF_FFFF_FF10, 0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,  64'h41, 64'h41);
      vecs[3]  = mkv(64'h50,  80'h1234_5678_9ABC_DEF0_1200, 0, 3'd2, 4'h0, 4'h0, 4'hF, 4'hF, 64'h0,  64'h51, 64'h51);
      vecs[4]  = mkv(64'h60,  80'h0000_0000_0000_000A_F230, 1, 3'd3, 4'h1, 4'h0, 4'hF, 4'h2, 64'hA,  64'h6A, 64'h6A);
      vecs[5]  = mkv(64'h70,  80'h0000_0000_0000_0000_00C0, 0, 3'd4, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,  64'h71, 64'h71);
      vecs[6]  = mkv(64'h80,  80'h0000_0000_0000_0000_1227, 0, 3'd4, 4'h1, 4'h7, 4'h1, 4'h2, 64'h0,  64'h82, 64'h82);
      vecs[7]  = mkv(64'h90,  80'h0000_0000_0000_0000_3426, 0, 3'd1, 4'h2, 4'h6, 4'h3, 4'h4, 64'h0,  64'h92, 64'h92);
      vecs[8]  = mkv(64'hA0,  80'h0000_0000_0000_0002_0080, 0, 3'd1, 4'h8, 4'h0, 4'hF, 4'hF, 64'h200, 64'hA9, 64'h200);
      vecs[9]  = mkv(64'hB0,  80'h1122_3344_5566_7788_1540, 0, 3'd1, 4'h4, 4'h0, 4'h1, 4'h5, 64'h1122334455667788, 64'hBA, 64'hBA);
      vecs[10] = mkv(64'hC0,  80'h0000_0000_0000_0000_0164, 0, 3'd4, 4'h1, 4'h4, 4'h0, 4'h1, 64'h0,  64'hC2, 64'hC2);
      vecs[11] = mkv(64'hFFFF_FFFF_FFFF_FFFF, NOP_DATA,     0, 3'd1, 4'h1, 4'h0, 4'hF, 4'hF, 64'h0,  64'h0,  64'h0);
      vecs[12] = mkv(64'hD0,  80'h0000_0000_0000_0000_0090, 0, 3'd1, 4'h9, 4'h0, 4'hF, 4'hF, 64'h0,  64'hD1, 64'hD1);
      vecs[13] = mkv(64'hE0,  80'h0000_0000_0000_0000_4FA0, 0, 3'd1, 4'hA, 4'h0, 4'h4, 4'hF, 64'h0,  64'hE2, 64'hE2);
      vecs[14] = mkv(64'hF0,  80'h0000_0000_0000_0000_2363, 0, 3'd1, 4'h6, 4'h3, 4'h2, 4'h3, 64'h0,  64'hF2, 64'hF2);
      vecs[15] = mkv(64'h100, 80'h0000_0000_0000_0000_4076, 0, 3'd1, 4'h7, 4'h6, 4'hF, 4'hF, 64'h40, 64'h109, 64'h40);
      vecs[16] = mkv(64'h110, 80'h0000_0000_0000_0005_6751, 0, 3'd4, 4'h1, 4'h1, 4'h6, 4'h7, 64'h5,  64'h11A, 64'h11A);

      reset = 1'b1; F_stall = 1'b0;
      M_icode = 4'h0; M_Cnd = 1'b1; M_valA = '0;
      W_icode = 4'h0; W_valM = '0;
      imem_error = 1'b0;
      imem_data = 80'h0000_0000_0000_000A_F230;
      tick(); tick();
      reset = 1'b0;
      #1;

      // Reset state and first fetch of irmovq $10,%rdx
      chk("rst.f_pc", f_pc, 64'h0);
      chk("rst.halted", {63'd0, f_halted}, 64'h0);
      chk("irm.stat", {61'd0, f_stat}, 64'd1);
      chk("irm.icode", {60'd0, f_icode}, 64'h3);
      chk("irm.rB", {60'd0, f_rB}, 64'h2);
      chk("irm.valC", f_valC, 64'hA);
      chk("irm.valP", f_valP, 64'hA);
      chk("irm.pred", f_predPC, 64'hA);
`ifdef FETCH_PERF_CNT_EN
      chk("rst.perf_f", perf_fetched, 64'h0);
      chk("rst.perf_r", perf_redirects, 64'h0);
`endif
      tick();
      chk("irm.next_pc", f_pc, 64'hA);

      // Table: aim the fetch PC with a W ret redirect while F is stalled
      F_stall = 1'b1;
      W_icode = 4'h9;
      for (int i = 0; i < 17; i++) begin
         W_valM     = vecs[i].pc;
         imem_data  = vecs[i].data;
         imem_error = vecs[i].err;
         #1;
         chk($sformatf("v%0d.pc", i), f_pc, vecs[i].pc);
         chk($sformatf("v%0d.addr", i), imem_addr, vecs[i].pc);
         chk($sformatf("v%0d.stat", i), {61'd0, f_stat}, {61'd0, vecs[i].stat});
         chk($sformatf("v%0d.icode", i), {60'd0, f_icode}, {60'd0, vecs[i].icode});
         chk($sformatf("v%0d.ifun", i), {60'd0, f_ifun}, {60'd0, vecs[i].ifun});
         chk($sformatf("v%0d.rA", i), {60'd0, f_rA}, {60'd0, vecs[i].rA});
         chk($sformatf("v%0d.rB", i), {60'd0, f_rB}, {60'd0, vecs[i].rB});
         chk($sformatf("v%0d.valC", i), f_valC, vecs[i].valC);
         chk($sformatf("v%0d.valP", i), f_valP, vecs[i].valP);
         chk($sformatf("v%0d.pred", i), f_predPC, vecs[i].pred);
      end
      W_icode = 4'h0; imem_error = 1'b0; F_stall = 1'b0;
      #1;
      chk("stall_kept_pc", f_pc, 64'hA);

      // Jump at 0x20 predicted to 0x100, then mispredicted back to 0x29
      imem_data = 80'h0000_0000_0000_0001_0070;
      W_icode = 4'h9; W_valM = 64'h20;
      #1;
      chk("jmp.pred", f_predPC, 64'h100);
      tick();
      W_icode = 4'h0; imem_data = NOP_DATA;
      #1;
      chk("jmp.taken_pc", f_pc, 64'h100);
      tick();
      chk("jmp.seq_pc", f_pc, 64'h101);
      M_icode = 4'h7; M_Cnd = 1'b0; M_valA = 64'h29;
      #1;
      chk("mis.f_pc", f_pc, 64'h29);
      W_icode = 4'h9; W_valM = 64'h500;
      #1;
      chk("mis_ret.f_pc", f_pc, 64'h29);
      chk("mis_ret.addr", imem_addr, 64'h29);
      tick();
      M_icode = 4'h0; M_Cnd = 1'b1; W_icode = 4'h0;
      #1;
      chk("mis_ret.next", f_pc, 64'h2A);

      // Stall three cycles at 0x40
      W_icode = 4'h9; W_valM = 64'h3F;
      tick();
      W_icode = 4'h0;
      #1;
      chk("stl.start", f_pc, 64'h40);
      F_stall = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("stl%0d.pc", c), f_pc, 64'h40);
         chk($sformatf("stl%0d.pred", c), f_predPC, 64'h41);
         chk($sformatf("stl%0d.stat", c), {61'd0, f_stat}, 64'd1);
      end
      F_stall = 1'b0;
      tick();
      chk("stl.release", f_pc, 64'h41);

      // Halt latches the stop; ret restarts fetch
      imem_data = '0;
      #1;
      chk("hlt.stat", {61'd0, f_stat}, 64'd2);
      chk("hlt.pre_latch", {63'd0, f_halted}, 64'h0);
      tick();
      chk("hlt.latched", {63'd0, f_halted}, 64'h1);
      chk("hlt.pc", f_pc, 64'h42);
      for (int c = 0; c < 4; c++) begin
         tick();
         chk($sformatf("hlt%0d.frozen", c), f_pc, 64'h42);
         chk($sformatf("hlt%0d.halted", c), {63'd0, f_halted}, 64'h1);
      end
      W_icode = 4'h9; W_valM = 64'h300; imem_data = NOP_DATA;
      #1;
      chk("hlt.ret_pc", f_pc, 64'h300);
      tick();
      W_icode = 4'h0;
      #1;
      chk("hlt.cleared", {63'd0, f_halted}, 64'h0);
      chk("hlt.resume", f_pc, 64'h301);
      tick();
      chk("hlt.resume2", f_pc, 64'h302);

      // Fault status also latches; reset under stall clears everything
      imem_error = 1'b1;
      tick();
      imem_error = 1'b0;
      #1;
      chk("adr.latched", {63'd0, f_halted}, 64'h1);
      F_stall = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0; F_stall = 1'b0;
      #1;
      chk("rst2.halted", {63'd0, f_halted}, 64'h0);
      chk("rst2.pc", f_pc, 64'h0);

`ifdef FETCH_PERF_CNT_EN
      chk("rst2.perf_f", perf_fetched, 64'h0);
      for (int c = 0; c < 5; c++) tick();
      chk("perf.fetched5", perf_fetched, 64'd5);
      chk("perf.redir0", perf_redirects, 64'd0);
      W_icode = 4'h9; W_valM = 64'h10;
      tick();
      W_icode = 4'h0;
      #1;
      chk("perf.redir1", perf_redirects, 64'd1);
      chk("perf.fetched6", perf_fetched, 64'd6);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
